// File: rtl/modos_multicanal.sv
// N-channel pet "need" tracker: saturating levels that decay on a shared
// seconds tick and refill on debounced recarga pulses. Each refill also
// starts a per-channel hold flag.

// One need channel: level, decay counter and hold timer.
module modos_canal #(
  parameter int LVL_W     = 2,
  parameter int DECAY_SEC = 10,
  parameter int HOLD_SEC  = 5,
  parameter int ALERT_LVL = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_tick,
  input  logic             i_recarga,
  input  logic             i_habilitar,
  output logic [LVL_W-1:0] o_nivel,
  output logic             o_vacio,
  output logic             o_alerta,
  output logic             o_senal
);
  localparam int DC_W = (DECAY_SEC < 2) ? 1 : $clog2(DECAY_SEC + 1);
  localparam int HD_W = (HOLD_SEC < 2) ? 1 : $clog2(HOLD_SEC + 1);
  localparam logic [LVL_W-1:0] FULL    = {LVL_W{1'b1}};
  localparam logic [DC_W-1:0]  DC_LAST = DC_W'(DECAY_SEC - 1);
  localparam logic [HD_W-1:0]  HD_LOAD = HD_W'(HOLD_SEC);

  logic [LVL_W-1:0] r_lvl;
  logic [DC_W-1:0]  r_dc;
  logic [HD_W-1:0]  r_hold;

  // Refill wins over a same-cycle tick; a disabled channel freezes entirely.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_lvl  <= FULL;
      r_dc   <= '0;
      r_hold <= '0;
    end else if (i_habilitar) begin
      if (i_recarga) begin
        r_lvl  <= (r_lvl == FULL) ? FULL : r_lvl + LVL_W'(1);
        r_dc   <= '0;
        r_hold <= HD_LOAD;
      end else if (i_tick) begin
        if (r_dc == DC_LAST) begin
          r_dc  <= '0;
          r_lvl <= (r_lvl == '0) ? '0 : r_lvl - LVL_W'(1);
        end else begin
          r_dc <= r_dc + DC_W'(1);
        end
        if (r_hold != '0)
          r_hold <= r_hold - HD_W'(1);
      end
    end
  end

  assign o_nivel  = r_lvl;
  assign o_vacio  = (r_lvl == '0);
  assign o_alerta = (32'(r_lvl) <= 32'(ALERT_LVL));
  assign o_senal  = (r_hold != '0);
endmodule

// Shared prescaler plus an array of channels.
module modos_multicanal #(
  parameter int N_CHAN    = 4,
  parameter int LVL_W     = 2,
  parameter int CLK_FREQ  = 50000000,
  parameter int TEST_DIV  = 10,
  parameter int DECAY_SEC = 10,
  parameter int HOLD_SEC  = 5,
  parameter int ALERT_LVL = 1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_test,
  input  logic [N_CHAN-1:0]       i_recarga,
  input  logic [N_CHAN-1:0]       i_habilitar,
  output logic [N_CHAN*LVL_W-1:0] o_nivel,
  output logic [N_CHAN-1:0]       o_vacio,
  output logic [N_CHAN-1:0]       o_alerta,
  output logic [N_CHAN-1:0]       o_senal_5seg,
  output logic                    o_tick_seg
);
  localparam int PS_W = (CLK_FREQ < 2) ? 1 : $clog2(CLK_FREQ + 1);
  localparam logic [PS_W-1:0] TERM_REAL = PS_W'(CLK_FREQ - 1);
  localparam logic [PS_W-1:0] TERM_TEST = PS_W'(CLK_FREQ / TEST_DIV - 1);

  logic [PS_W-1:0] r_ps;
  logic            r_tick;
  logic            r_test_q;
  logic [PS_W-1:0] w_term;
  logic [N_CHAN-1:0][LVL_W-1:0] w_nivel;

  assign w_term = i_test ? TERM_TEST : TERM_REAL;

  // Prescaler: a mode switch restarts the second so the new rate starts clean.
  // The >= guards against any count left above the terminal value.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ps     <= '0;
      r_tick   <= 1'b0;
      r_test_q <= i_test;
    end else begin
      r_test_q <= i_test;
      if (i_test != r_test_q) begin
        r_ps   <= '0;
        r_tick <= 1'b0;
      end else if (r_ps >= w_term) begin
        r_ps   <= '0;
        r_tick <= 1'b1;
      end else begin
        r_ps   <= r_ps + PS_W'(1);
        r_tick <= 1'b0;
      end
    end
  end

  assign o_tick_seg = r_tick;

  for (genvar g = 0; g < N_CHAN; g++) begin : g_chan
    modos_canal #(
      .LVL_W     (LVL_W),
      .DECAY_SEC (DECAY_SEC),
      .HOLD_SEC  (HOLD_SEC),
      .ALERT_LVL (ALERT_LVL)
    ) u_canal (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_tick      (r_tick),
      .i_recarga   (i_recarga[g]),
      .i_habilitar (i_habilitar[g]),
      .o_nivel     (w_nivel[g]),
      .o_vacio     (o_vacio[g]),
      .o_alerta    (o_alerta[g]),
      .o_senal     (o_senal_5seg[g])
    );
  end

  // Packed layout puts channel i at [i*LVL_W +: LVL_W].
  assign o_nivel = w_nivel;
endmodule

// File: tb/tb_modos_multicanal.sv
// Randomized bench for modos_multicanal: a reference model predicts the
// outputs after every clock edge; a monitor pops and compares them.
module tb_modos_multicanal;
  localparam int NC = 4, LW = 2, CF = 20, TD = 4, DS = 3, HS = 2, AL = 1;
  localparam int FULLV = 3;

  logic            clk = 1'b0;
  logic            rst, test;
  logic [NC-1:0]   rec, hab;
  logic [NC*LW-1:0] nivel;
  logic [NC-1:0]   vacio, alerta, senal;
  logic            tick;

  modos_multicanal #(
    .N_CHAN(NC), .LVL_W(LW), .CLK_FREQ(CF), .TEST_DIV(TD),
    .DECAY_SEC(DS), .HOLD_SEC(HS), .ALERT_LVL(AL)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_test(test), .i_recarga(rec),
    .i_habilitar(hab), .o_nivel(nivel), .o_vacio(vacio), .o_alerta(alerta),
    .o_senal_5seg(senal), .o_tick_seg(tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NC*LW-1:0] nivel;
    logic [NC-1:0]    vacio;
    logic [NC-1:0]    alerta;
    logic [NC-1:0]    senal;
    logic             tick;
  } exp_t;

  exp_t q[$];
  int n_chk = 0, n_pass = 0;

  // Reference model: levels as integers, seconds counted in whole ticks.
  int m_lvl [NC];
  int m_age [NC];   // ticks since last decay or refill
  int m_hold[NC];   // seconds left on the activity flag
  int m_since;      // cycles into the current second
  bit m_tick, m_prev_test;

  task automatic model_step(input bit r, input bit t, input bit [NC-1:0] rc,
                            input bit [NC-1:0] hb);
    int period;
    if (r) begin
      for (int c = 0; c < NC; c++) begin
        m_lvl[c] = FULLV; m_age[c] = 0; m_hold[c] = 0;
      end
      m_since = 0; m_tick = 0; m_prev_test = t;
      return;
    end
    for (int c = 0; c < NC; c++) begin
      if (!hb[c]) continue;
      if (rc[c]) begin
        m_lvl[c]  = (m_lvl[c] + 1 > FULLV) ? FULLV : m_lvl[c] + 1;
        m_age[c]  = 0;
        m_hold[c] = HS;
      end else if (m_tick) begin
        m_age[c]++;
        if (m_age[c] == DS) begin
          m_age[c] = 0;
          m_lvl[c] = (m_lvl[c] - 1 < 0) ? 0 : m_lvl[c] - 1;
        end
        if (m_hold[c] > 0) m_hold[c]--;
      end
    end
    period = t ? CF / TD : CF;
    if (t != m_prev_test) begin
      m_since = 0; m_tick = 0;
    end else if (m_since + 1 >= period) begin
      m_since = 0; m_tick = 1;
    end else begin
      m_since++; m_tick = 0;
    end
    m_prev_test = t;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e = '0;
    for (int c = 0; c < NC; c++) begin
      e.nivel[c*LW +: LW] = LW'(m_lvl[c]);
      e.vacio[c]  = (m_lvl[c] == 0);
      e.alerta[c] = (m_lvl[c] <= AL);
      e.senal[c]  = (m_hold[c] > 0);
    end
    e.tick = m_tick;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
  endtask

  // Monitor: the DUT presents a fresh state every cycle; compare mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("nivel",  32'(nivel),  32'(e.nivel));
      chk("vacio",  32'(vacio),  32'(e.vacio));
      chk("alerta", 32'(alerta), 32'(e.alerta));
      chk("senal",  32'(senal),  32'(e.senal));
      chk("tick",   32'(tick),   32'(e.tick));
    end
  end

  // Apply the inputs currently driven at the next edge and queue the prediction.
  task automatic cycle();
    @(posedge clk);
    #1;
    model_step(rst, test, rec, hab);
    q.push_back(model_out());
  endtask

  initial begin
    rst = 1'b1; test = 1'b0; rec = '0; hab = '1;
    for (int c = 0; c < NC; c++) begin
      m_lvl[c] = 0; m_age[c] = 0; m_hold[c] = 0;
    end
    m_since = 0; m_tick = 0; m_prev_test = 0;

    // Reset, then free-running decay in real-time mode down to empty.
    cycle(); cycle();
    rst = 1'b0;
    for (int i = 0; i < 260; i++) cycle();

    // Accelerated mode with random refills, test toggles, freezes and resets.
    test = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      rec = '0;
      for (int c = 0; c < NC; c++)
        if ($urandom_range(0, 5) == 0) rec[c] = 1'b1;
      if ($urandom_range(0, 39) == 0) hab[$urandom_range(0, NC - 1)] ^= 1'b1;
      if ($urandom_range(0, 49) == 0) test = ~test;
      rst = ($urandom_range(0, 299) == 0);
      if (i >= 1500 && i < 1600) hab[2] = 1'b0;
      cycle();
    end

    // Idle tail in test mode: everything decays again.
    rst = 1'b0; rec = '0; hab = '1; test = 1'b1;
    for (int i = 0; i < 80; i++) cycle();

    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending want 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
